// File: rtl/clkgen_multi.sv
// ---------------------------------------------------------------------------
// clkgen_multi
//   Clock / strobe generator running entirely on globalclock. Produces:
//     - an ADC clock (fixed half-period) plus a copy delayed by ADC_DELAY
//       enabled cycles,
//     - a DAC clock whose half-period can be reprogrammed at runtime; a new
//       ratio is only applied on a counter wrap, so no runt pulses occur,
//     - a UART baud clock with programmable rise point (duty),
//     - single-cycle strobes (dac_rise, uart_tick) that coincide with the
//       first high cycle of dac_clk / uart_clk, for use as clock enables.
//
// Ports
//   globalclock   in   1      system clock
//   rst           in   1      asynchronous active-high reset
//   en            in   1      run enable; low freezes counters/clocks/delay
//   dac_load      in   1      strobe capturing dac_half_in (ignored if 0)
//   dac_half_in   in   CNT_W  new DAC half-period
//   adc_clk       out  1      divided ADC clock
//   adc_clk_delay out  1      adc_clk delayed by ADC_DELAY enabled cycles
//   dac_clk       out  1      divided DAC clock
//   dac_rise      out  1      pulse coincident with dac_clk going high
//   uart_clk      out  1      UART baud clock
//   uart_tick     out  1      pulse coincident with uart_clk going high
//   dac_half_act  out  CNT_W  DAC half-period currently in use
// ---------------------------------------------------------------------------
module clkgen_multi #(
  parameter int CNT_W        = 16,
  parameter int ADC_HALF     = 1,
  parameter int ADC_DELAY    = 1,
  parameter int DAC_HALF_RST = 2,
  parameter int UART_PERIOD  = 27,
  parameter int UART_RISE    = 13
) (
  input  logic             globalclock,
  input  logic             rst,
  input  logic             en,
  input  logic             dac_load,
  input  logic [CNT_W-1:0] dac_half_in,
  output logic             adc_clk,
  output logic             adc_clk_delay,
  output logic             dac_clk,
  output logic             dac_rise,
  output logic             uart_clk,
  output logic             uart_tick,
  output logic [CNT_W-1:0] dac_half_act
);

  localparam logic [CNT_W-1:0] ADC_LAST  = CNT_W'(ADC_HALF - 1);
  localparam logic [CNT_W-1:0] UART_LAST = CNT_W'(UART_PERIOD - 1);
  localparam logic [CNT_W-1:0] UART_HI   = CNT_W'(UART_RISE);
  localparam logic [CNT_W-1:0] DAC_RST_V = CNT_W'(DAC_HALF_RST);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  // -------------------------------------------------------------------------
  // ADC divider
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] acnt_reg;
  logic             adc_clk_reg;

  always_ff @(posedge globalclock or posedge rst) begin
    if (rst) begin
      acnt_reg    <= '0;
      adc_clk_reg <= 1'b0;
    end else if (en) begin
      if (acnt_reg == ADC_LAST) begin
        acnt_reg    <= '0;
        adc_clk_reg <= ~adc_clk_reg;
      end else begin
        acnt_reg <= acnt_reg + ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // ADC delay line: stage 0 holds adc_clk from one enabled cycle ago, the
  // last stage holds it from ADC_DELAY enabled cycles ago.
  // -------------------------------------------------------------------------
  logic [ADC_DELAY-1:0] dly_reg;
  logic [ADC_DELAY-1:0] dly_next;

  generate
    for (genvar gi = 0; gi < ADC_DELAY; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        assign dly_next[gi] = adc_clk_reg;
      end else begin : g_tail
        assign dly_next[gi] = dly_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge globalclock or posedge rst) begin
    if (rst) begin
      dly_reg <= '0;
    end else if (en) begin
      dly_reg <= dly_next;
    end
  end

  // -------------------------------------------------------------------------
  // DAC divider with deferred reload
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] dcnt_reg;
  logic             dac_clk_reg;
  logic             dac_rise_reg;
  logic [CNT_W-1:0] dac_half_act_reg;
  logic [CNT_W-1:0] pend_reg;
  logic             pend_vld_reg;
  logic [CNT_W-1:0] dac_last;
  logic             load_ok;

  assign dac_last = dac_half_act_reg - ONE;
  // A zero half-period would never wrap, so such loads are discarded.
  assign load_ok  = dac_load && (dac_half_in != '0);

  always_ff @(posedge globalclock or posedge rst) begin
    if (rst) begin
      dcnt_reg         <= '0;
      dac_clk_reg      <= 1'b0;
      dac_rise_reg     <= 1'b0;
      dac_half_act_reg <= DAC_RST_V;
      pend_reg         <= '0;
      pend_vld_reg     <= 1'b0;
    end else begin
      dac_rise_reg <= 1'b0;
      // Loads are captured even while stopped; last one before a wrap wins.
      if (load_ok) begin
        pend_reg     <= dac_half_in;
        pend_vld_reg <= 1'b1;
      end
      if (en) begin
        if (dcnt_reg == dac_last) begin
          dcnt_reg     <= '0;
          dac_clk_reg  <= ~dac_clk_reg;
          dac_rise_reg <= ~dac_clk_reg;
          // The wrap sees only the pending state from before this edge; a
          // load arriving on the same edge stays pending for the next wrap.
          if (pend_vld_reg) begin
            dac_half_act_reg <= pend_reg;
            if (!load_ok) begin
              pend_vld_reg <= 1'b0;
            end
          end
        end else begin
          dcnt_reg <= dcnt_reg + ONE;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // UART baud generator: rises after ucnt == UART_RISE, falls on wrap.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] ucnt_reg;
  logic             uart_clk_reg;
  logic             uart_tick_reg;

  always_ff @(posedge globalclock or posedge rst) begin
    if (rst) begin
      ucnt_reg      <= '0;
      uart_clk_reg  <= 1'b0;
      uart_tick_reg <= 1'b0;
    end else begin
      uart_tick_reg <= 1'b0;
      if (en) begin
        if (ucnt_reg == UART_LAST) begin
          ucnt_reg     <= '0;
          uart_clk_reg <= 1'b0;
        end else begin
          ucnt_reg <= ucnt_reg + ONE;
        end
        if (ucnt_reg == UART_HI) begin
          uart_clk_reg  <= 1'b1;
          uart_tick_reg <= 1'b1;
        end
      end
    end
  end

  assign adc_clk       = adc_clk_reg;
  assign adc_clk_delay = dly_reg[ADC_DELAY-1];
  assign dac_clk       = dac_clk_reg;
  assign dac_rise      = dac_rise_reg;
  assign uart_clk      = uart_clk_reg;
  assign uart_tick     = uart_tick_reg;
  assign dac_half_act  = dac_half_act_reg;

endmodule

// File: tb/tb_clkgen_multi.sv
// ---------------------------------------------------------------------------
// tb_clkgen_multi
//   Directed bench for clkgen_multi. Instance a uses default parameters,
//   instance b uses ADC_HALF=3, ADC_DELAY=4 and shares all inputs.
// ---------------------------------------------------------------------------
module tb_clkgen_multi;

  localparam int CW          = 16;
  localparam int A_ADC_HALF  = 1;
  localparam int A_ADC_DELAY = 1;
  localparam int B_ADC_HALF  = 3;
  localparam int B_ADC_DELAY = 4;
  localparam int DAC_RST     = 2;
  localparam int U_PER       = 27;
  localparam int U_RISE      = 13;

  logic          globalclock = 1'b0;
  logic          rst         = 1'b0;
  logic          en          = 1'b0;
  logic          dac_load    = 1'b0;
  logic [CW-1:0] dac_half_in = '0;

  logic          a_adc, a_adcd, a_dac, a_rise, a_uart, a_tick;
  logic [CW-1:0] a_act;
  logic          b_adc, b_adcd, b_dac, b_rise, b_uart, b_tick;
  logic [CW-1:0] b_act;

  int checks   = 0;
  int failures = 0;

  clkgen_multi #(
    .CNT_W(CW), .ADC_HALF(A_ADC_HALF), .ADC_DELAY(A_ADC_DELAY),
    .DAC_HALF_RST(DAC_RST), .UART_PERIOD(U_PER), .UART_RISE(U_RISE)
  ) u_a (
    .globalclock(globalclock), .rst(rst), .en(en), .dac_load(dac_load),
    .dac_half_in(dac_half_in), .adc_clk(a_adc), .adc_clk_delay(a_adcd),
    .dac_clk(a_dac), .dac_rise(a_rise), .uart_clk(a_uart),
    .uart_tick(a_tick), .dac_half_act(a_act)
  );

  clkgen_multi #(
    .CNT_W(CW), .ADC_HALF(B_ADC_HALF), .ADC_DELAY(B_ADC_DELAY),
    .DAC_HALF_RST(DAC_RST), .UART_PERIOD(U_PER), .UART_RISE(U_RISE)
  ) u_b (
    .globalclock(globalclock), .rst(rst), .en(en), .dac_load(dac_load),
    .dac_half_in(dac_half_in), .adc_clk(b_adc), .adc_clk_delay(b_adcd),
    .dac_clk(b_dac), .dac_rise(b_rise), .uart_clk(b_uart),
    .uart_tick(b_tick), .dac_half_act(b_act)
  );

  always #5 globalclock = ~globalclock;

  // Parameter legality for both instances.
  initial begin
    assert (A_ADC_HALF >= 1 && B_ADC_HALF >= 1 &&
            A_ADC_DELAY >= 1 && A_ADC_DELAY <= 16 &&
            B_ADC_DELAY >= 1 && B_ADC_DELAY <= 16 &&
            DAC_RST >= 1 && U_PER >= 3 && U_RISE >= 0 && U_RISE <= U_PER - 2)
      else $fatal(1, "FAIL param_range illegal generator parameters");
  end

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge globalclock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a_adc"},  32'(a_adc),  0);
    chk({tag, "_a_adcd"}, 32'(a_adcd), 0);
    chk({tag, "_a_dac"},  32'(a_dac),  0);
    chk({tag, "_a_rise"}, 32'(a_rise), 0);
    chk({tag, "_a_uart"}, 32'(a_uart), 0);
    chk({tag, "_a_tick"}, 32'(a_tick), 0);
    chk({tag, "_a_act"},  32'(a_act),  DAC_RST);
    chk({tag, "_b_adc"},  32'(b_adc),  0);
    chk({tag, "_b_adcd"}, 32'(b_adcd), 0);
  endtask

  initial begin
    int n;
    bit on;
    // ---------------- reset values ----------------
    #1 rst = 1'b1;
    #1 chk_reset_state("reset");
    step();
    rst = 1'b0;
    en  = 1'b1;
    chk_reset_state("post_release");

    // ------- defaults free run, with a 20-cycle en=0 hold at n=30 -------
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      on = !(i >= 31 && i <= 50);
      en = on;
      step();
      if (on) n++;
      chk($sformatf("adc@%0d", n),       32'(a_adc),  32'(n % 2));
      chk($sformatf("adcd@%0d", n),      32'(a_adcd), (n >= 1) ? 32'((n - 1) % 2) : 0);
      chk($sformatf("dac@%0d", n),       32'(a_dac),  32'((n % 4) >= 2));
      chk($sformatf("dac_rise@%0d", n),  32'(a_rise), 32'(on && (n % 4) == 2));
      chk($sformatf("uart@%0d", n),      32'(a_uart), 32'((n % U_PER) >= 14));
      chk($sformatf("uart_tick@%0d", n), 32'(a_tick), 32'(on && (n % U_PER) == 14));
      chk($sformatf("act@%0d", n),       32'(a_act),  DAC_RST);
      chk($sformatf("b_adc@%0d", n),     32'(b_adc),  32'((n / 3) % 2));
      chk($sformatf("b_adcd@%0d", n),    32'(b_adcd), (n >= 4) ? 32'(((n - 4) / 3) % 2) : 0);
    end

    // ---------------- DAC reload sequence ----------------
    rst = 1'b1;
    #2 rst = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 53; k++) begin
      int exp_dac, exp_rise, exp_act;
      dac_load    = (k == 1 || k == 23 || k == 25 || k == 28 || k == 39 || k == 53);
      dac_half_in = (k == 1)  ? 16'd5 :
                    (k == 23) ? 16'd7 :
                    (k == 25) ? 16'd3 :
                    (k == 39) ? 16'd4 :
                    (k == 53) ? 16'd9 : 16'd0;
      step();
      dac_load = 1'b0;
      if (k < 2) begin
        exp_dac = 0; exp_rise = 0; exp_act = 2;
      end else if (k < 27) begin
        exp_dac  = (((k - 2) / 5) % 2 == 0) ? 1 : 0;
        exp_rise = (k == 2 || k == 12 || k == 22) ? 1 : 0;
        exp_act  = 5;
      end else if (k < 42) begin
        exp_dac  = (((k - 27) / 3) % 2 == 0) ? 0 : 1;
        exp_rise = ((k - 27) % 6 == 3) ? 1 : 0;
        exp_act  = 3;
      end else begin
        exp_dac  = (((k - 42) / 4) % 2 == 0) ? 1 : 0;
        exp_rise = ((k - 42) % 8 == 0) ? 1 : 0;
        exp_act  = 4;
      end
      chk($sformatf("rl_dac@%0d", k),  32'(a_dac),  exp_dac);
      chk($sformatf("rl_rise@%0d", k), 32'(a_rise), exp_rise);
      chk($sformatf("rl_act@%0d", k),  32'(a_act),  exp_act);
      chk($sformatf("rl_uart@%0d", k), 32'(a_uart), 32'((k % U_PER) >= 14));
      chk($sformatf("rl_tick@%0d", k), 32'(a_tick), 32'((k % U_PER) == 14));
    end

    // ------- async reset between edges: uart high, load 9 pending -------
    #2 rst = 1'b1;
    #1 chk_reset_state("async_rst");
    #1 rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("post_rst_act@%0d", k), 32'(a_act), DAC_RST);
      chk($sformatf("post_rst_dac@%0d", k), 32'(a_dac), 32'((k % 4) >= 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
